ifetch_predecode: RTL and testbench

IFETCH_PREDECODE -- requirements
Module: ifetch_predecode

---
 rtl/isa_pkg.sv | 40 ++++
 rtl/ifetch_predecode_if.sv | 39 +++
 rtl/op_predecode.sv | 37 +++
 rtl/ifetch_predecode.sv | 126 ++++++++++++
 tb/tb_ifetch_predecode.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants, fetch FSM state encoding and predecode payload for the
// instruction fetch / predecode block.
package isa_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic rtype;
    logic ori;
    logic addiu;
    logic lw;
    logic sw;
    logic beq;
    logic jump;
    logic illegal;
  } predec_t;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{(XLEN-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_predecode_if.sv
// Fetch-unit bus: instruction-memory read port, held-instruction/decode port and
// the branch/jump controls coming back from the main controller.
interface ifetch_predecode_if;

  logic                      imem_req;
  logic [isa_pkg::XLEN-1:0]  imem_addr;
  logic                      imem_ack;
  logic [isa_pkg::XLEN-1:0]  imem_rdata;

  logic [isa_pkg::XLEN-1:0]  instr;
  logic                      instr_valid;
  logic                      instr_accept;
  logic                      branch;
  logic                      jump_in;
  logic                      zero;
  logic [isa_pkg::XLEN-1:0]  pc;

  logic                      Rtype;
  logic                      ori;
  logic                      addiu;
  logic                      lw;
  logic                      sw;
  logic                      beq;
  logic                      jump;
  logic                      illegal;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc,
           Rtype, ori, addiu, lw, sw, beq, jump, illegal,
    input  imem_ack, imem_rdata, instr_accept, branch, jump_in, zero
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc,
           Rtype, ori, addiu, lw, sw, beq, jump, illegal,
    output imem_ack, imem_rdata, instr_accept, branch, jump_in, zero
  );

endinterface

// File: rtl/op_predecode.sv
// Combinational one-hot opcode decode; unknown opcodes raise illegal only.
module op_predecode
  import isa_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output logic           rtype_o,
  output logic           ori_o,
  output logic           addiu_o,
  output logic           lw_o,
  output logic           sw_o,
  output logic           beq_o,
  output logic           jump_o,
  output logic           illegal_o
);

  always_comb begin
    rtype_o   = 1'b0;
    ori_o     = 1'b0;
    addiu_o   = 1'b0;
    lw_o      = 1'b0;
    sw_o      = 1'b0;
    beq_o     = 1'b0;
    jump_o    = 1'b0;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: rtype_o   = 1'b1;
      OP_ORI:   ori_o     = 1'b1;
      OP_ADDIU: addiu_o   = 1'b1;
      OP_LW:    lw_o      = 1'b1;
      OP_SW:    sw_o      = 1'b1;
      OP_BEQ:   beq_o     = 1'b1;
      OP_J:     jump_o    = 1'b1;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ifetch_predecode.sv
// Instruction fetch FSM: requests the word at pc, holds it with its registered
// predecode until downstream accepts, then advances pc by jump/branch/pc+4.
module ifetch_predecode
  import isa_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  ifetch_predecode_if.master  bus
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  predec_t         dec_q, dec_d;

  predec_t         rdata_dec;
  logic            dec_rtype, dec_ori, dec_addiu, dec_lw, dec_sw, dec_beq, dec_jump, dec_illegal;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] next_pc;

  // Decode the incoming word so the held decode is registered alongside instr.
  op_predecode u_op_predecode (
    .opcode_i  (bus.imem_rdata[XLEN-1:XLEN-OPW]),
    .rtype_o   (dec_rtype),
    .ori_o     (dec_ori),
    .addiu_o   (dec_addiu),
    .lw_o      (dec_lw),
    .sw_o      (dec_sw),
    .beq_o     (dec_beq),
    .jump_o    (dec_jump),
    .illegal_o (dec_illegal)
  );

  assign rdata_dec = '{rtype: dec_rtype, ori: dec_ori, addiu: dec_addiu, lw: dec_lw,
                       sw: dec_sw, beq: dec_beq, jump: dec_jump, illegal: dec_illegal};

  assign pc4 = pc_q + XLEN'(4);

  // Jump outranks a taken branch when the controller raises both.
  always_comb begin
    next_pc = pc4;
    if (bus.jump_in) begin
      next_pc = {pc4[XLEN-1:XLEN-4], instr_q[25:0], 2'b00};
    end else if (bus.branch && bus.zero) begin
      next_pc = pc4 + branch_offset(instr_q[15:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    dec_d   = dec_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          state_d = HOLD;
          instr_d = bus.imem_rdata;
          dec_d   = rdata_dec;
          valid_d = 1'b1;
          req_d   = 1'b0;
        end
      end
      HOLD: begin
        if (bus.instr_accept) begin
          state_d = FETCH;
          pc_d    = next_pc;
          dec_d   = '0;
          valid_d = 1'b0;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
        dec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.Rtype       = dec_q.rtype;
  assign bus.ori         = dec_q.ori;
  assign bus.addiu       = dec_q.addiu;
  assign bus.lw          = dec_q.lw;
  assign bus.sw          = dec_q.sw;
  assign bus.beq         = dec_q.beq;
  assign bus.jump        = dec_q.jump;
  assign bus.illegal     = dec_q.illegal;

endmodule

// File: tb/tb_ifetch_predecode.sv
// Self-checking bench for ifetch_predecode: directed scenarios plus randomized
// fetch/accept traffic checked against a behavioural pc/decode model.
module tb_ifetch_predecode;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  ifetch_predecode_if bus ();

  ifetch_predecode #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected decode {Rtype,ori,addiu,lw,sw,beq,jump,illegal} from the opcode table.
  function automatic logic [7:0] model_dec(input logic [31:0] w);
    logic [5:0] ops [7];
    logic [7:0] r;
    ops = '{6'b000000, 6'b001101, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    r = 8'h00;
    for (int i = 0; i < 7; i++) if (w[31:26] == ops[i]) r[7-i] = 1'b1;
    if (r == 8'h00) r[0] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit j, input bit b, input bit z);
    logic [31:0] pc4;
    int off;
    pc4 = pc + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    off = $signed(w[15:0]);
    if (b && z) return pc4 + 32'(off * 4);
    return pc4;
  endfunction

  function automatic logic [7:0] obs_dec();
    return {bus.Rtype, bus.ori, bus.addiu, bus.lw, bus.sw, bus.beq, bus.jump, bus.illegal};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return model_dec({op, 26'd0}) != 8'h01;
  endfunction

  // Wait (bounded) for a request, stall `delay` cycles, then return the word.
  task automatic deliver(input logic [31:0] w, input int delay, input bit noise);
    int waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL deliver_req_timeout: imem_req=%b required 1", bus.imem_req);
    end
    for (int i = 0; i < delay; i++) begin
      if (noise) bus.instr_accept = 1'($urandom % 2);
      @(negedge clk);
    end
    bus.instr_accept = 1'b0;
    bus.imem_ack     = 1'b1;
    bus.imem_rdata   = w;
    @(negedge clk);
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = $urandom;
  endtask

  task automatic accept_with(input bit j, input bit b, input bit z);
    bus.jump_in      = j;
    bus.branch       = b;
    bus.zero         = z;
    bus.instr_accept = 1'b1;
    @(negedge clk);
    bus.instr_accept = 1'b0;
    bus.jump_in      = 1'b0;
    bus.branch       = 1'b0;
    bus.zero         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req=%b valid=%b required 0 0", bus.imem_req, bus.instr_valid);
    end
    n_tests++;
    if (bus.pc !== RST_PC || bus.instr !== 32'h0 || obs_dec() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h instr=%h dec=%b required %h 0 0", bus.pc, bus.instr, obs_dec(), RST_PC);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: req=%b required 0", bus.imem_req);
    end
    @(negedge clk);
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_fetch: req=%b addr=%h valid=%b required 1 %h 0", bus.imem_req, bus.imem_addr, bus.instr_valid, RST_PC);
    end
    m_pc = RST_PC;
  endtask

  task automatic test_ori_fetch();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000 || bus.instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ori_wait: req=%b addr=%h valid=%b required 1 3000 0", bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      @(negedge clk);
    end
    deliver(32'h3421_0005, 0, 1'b0);
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h3421_0005 || obs_dec() !== 8'b0100_0000 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ori_hold: valid=%b instr=%h dec=%b req=%b required 1 34210005 01000000 0", bus.instr_valid, bus.instr, obs_dec(), bus.imem_req);
    end
    accept_with(1'b0, 1'b0, 1'b0);
    m_pc = 32'h3004;
    n_tests++;
    if (bus.imem_addr !== 32'h3004 || bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || obs_dec() !== 8'h00) begin
      n_fail++;
      $display("FAIL ori_advance: addr=%h req=%b valid=%b dec=%b required 3004 1 0 0", bus.imem_addr, bus.imem_req, bus.instr_valid, obs_dec());
    end
  endtask

  task automatic test_branch();
    deliver(32'h2408_0001, 0, 1'b0);
    accept_with(1'b0, 1'b0, 1'b0);
    deliver(32'h1000_FFFE, 1, 1'b0);
    n_tests++;
    if (bus.pc !== 32'h3008 || obs_dec() !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL beq_hold: pc=%h dec=%b required 3008 00000100", bus.pc, obs_dec());
    end
    accept_with(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (bus.pc !== 32'h3004) begin
      n_fail++;
      $display("FAIL beq_taken: pc=%h required 3004", bus.pc);
    end
    deliver(32'h2408_0002, 2, 1'b0);
    accept_with(1'b0, 1'b0, 1'b0);
    deliver(32'h1000_FFFE, 0, 1'b0);
    accept_with(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (bus.pc !== 32'h300C || bus.imem_addr !== 32'h300C) begin
      n_fail++;
      $display("FAIL beq_not_taken: pc=%h addr=%h required 300c", bus.pc, bus.imem_addr);
    end
    m_pc = 32'h300C;
  endtask

  task automatic test_jump();
    deliver(32'h0800_0C10, 1, 1'b0);
    n_tests++;
    if (obs_dec() !== 8'b0000_0010) begin
      n_fail++;
      $display("FAIL jump_dec: dec=%b required 00000010", obs_dec());
    end
    accept_with(1'b1, 1'b1, 1'b1);
    n_tests++;
    if (bus.pc !== 32'h0000_3040) begin
      n_fail++;
      $display("FAIL jump_target: pc=%h required 00003040", bus.pc);
    end
    m_pc = 32'h0000_3040;
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    w = {6'b111111, 26'($urandom)};
    deliver(w, 0, 1'b0);
    n_tests++;
    if (bus.instr_valid !== 1'b1 || obs_dec() !== 8'h01) begin
      n_fail++;
      $display("FAIL illegal_dec: valid=%b dec=%b required 1 00000001", bus.instr_valid, obs_dec());
    end
    accept_with(1'b0, 1'b0, 1'b0);
    m_pc = m_pc + 32'd4;
    n_tests++;
    if (bus.pc !== m_pc || obs_dec() !== 8'h00) begin
      n_fail++;
      $display("FAIL illegal_advance: pc=%h dec=%b required %h 0", bus.pc, obs_dec(), m_pc);
    end
  endtask

  task automatic test_reset_midfetch();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.pc !== RST_PC || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_fetch_async: req=%b pc=%h valid=%b instr=%h required 0 %h 0 0", bus.imem_req, bus.pc, bus.instr_valid, bus.instr, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h3421_0005;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
        n_fail++;
        $display("FAIL rst_stray_ack: valid=%b req=%b addr=%h required 0 1 %h", bus.instr_valid, bus.imem_req, bus.imem_addr, RST_PC);
      end
      @(negedge clk);
    end
    deliver(32'h8C22_0010, 1, 1'b0);
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h8C22_0010 || obs_dec() !== 8'b0001_0000) begin
      n_fail++;
      $display("FAIL rst_fresh_ack: valid=%b instr=%h dec=%b required 1 8c220010 00010000", bus.instr_valid, bus.instr, obs_dec());
    end
    // Reset while holding must drop the held instruction.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.instr_valid !== 1'b0 || obs_dec() !== 8'h00 || bus.instr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_hold_async: valid=%b dec=%b instr=%h required 0 0 0", bus.instr_valid, obs_dec(), bus.instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_pc = RST_PC;
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rst_hold_refetch: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_accept_held();
    int delays [3];
    logic [31:0] w;
    delays = '{0, 1, 4};
    bus.instr_accept = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = {6'b001001, 26'($urandom)};
      for (int i = 0; i < delays[k]; i++) begin
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.pc !== m_pc || bus.instr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL held_wait: req=%b pc=%h valid=%b required 1 %h 0", bus.imem_req, bus.pc, bus.instr_valid, m_pc);
        end
        @(negedge clk);
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = w;
      @(negedge clk);
      bus.imem_ack   = 1'b0;
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== w || bus.pc !== m_pc) begin
        n_fail++;
        $display("FAIL held_hold: valid=%b instr=%h pc=%h required 1 %h %h", bus.instr_valid, bus.instr, bus.pc, w, m_pc);
      end
      @(negedge clk);
      m_pc = m_pc + 32'd4;
      n_tests++;
      if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.pc !== m_pc) begin
        n_fail++;
        $display("FAIL held_advance: valid=%b req=%b pc=%h required 0 1 %h", bus.instr_valid, bus.imem_req, bus.pc, m_pc);
      end
    end
    bus.instr_accept = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] legal [7];
    logic [5:0] op;
    logic [31:0] w;
    bit j, b, z;
    legal = '{6'b000000, 6'b001101, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    for (int it = 0; it < 40; it++) begin
      if ($urandom % 8 == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal[$urandom % 7];
      end
      w = {op, 26'($urandom)};
      deliver(w, int'($urandom % 4), 1'b1);
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== w || obs_dec() !== model_dec(w) ||
          bus.pc !== m_pc || bus.imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_hold[%0d]: valid=%b instr=%h dec=%b pc=%h req=%b required 1 %h %b %h 0",
                 it, bus.instr_valid, bus.instr, obs_dec(), bus.pc, bus.imem_req, w, model_dec(w), m_pc);
      end
      for (int h = 0; h < int'($urandom % 3); h++) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = ~w;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        n_tests++;
        if (bus.instr !== w || bus.instr_valid !== 1'b1 || obs_dec() !== model_dec(w)) begin
          n_fail++;
          $display("FAIL rand_stray_ack[%0d]: instr=%h valid=%b dec=%b required %h 1 %b", it, bus.instr, bus.instr_valid, obs_dec(), w, model_dec(w));
        end
      end
      j = 1'($urandom % 4 == 0);
      b = 1'($urandom % 2);
      z = 1'($urandom % 2);
      accept_with(j, b, z);
      m_pc = model_next(m_pc, w, j, b, z);
      n_tests++;
      if (bus.pc !== m_pc || bus.imem_addr !== m_pc || bus.imem_req !== 1'b1 ||
          bus.instr_valid !== 1'b0 || obs_dec() !== 8'h00) begin
        n_fail++;
        $display("FAIL rand_next[%0d]: pc=%h addr=%h req=%b valid=%b dec=%b required %h 1 0 0 (j=%0d b=%0d z=%0d)",
                 it, bus.pc, bus.imem_addr, bus.imem_req, bus.instr_valid, obs_dec(), m_pc, j, b, z);
      end
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.instr_accept = 1'b0;
    bus.branch       = 1'b0;
    bus.jump_in      = 1'b0;
    bus.zero         = 1'b0;
    m_pc             = RST_PC;
    test_reset();
    test_ori_fetch();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_midfetch();
    test_accept_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
